wb_arbiter: RTL and testbench

- Write-back arbiter and scoreboard for the LEGv8 datapath; the writer side of the 64x32 register file.
- Merges two result sources into the register file's single write port:
  - the single-cycle ALU path, which has priority;
  - the long-latency load/multiply path, buffered in a small FIFO.
- Tracks pending long-latency destinations so decode can stall on RAW hazards.
- Drives the register file's WriteSelect/WriteData/WriteEnable directly.

---
 rtl/wb_arbiter.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter and RAW scoreboard for the LEGv8 datapath.
// Merges the single-cycle ALU result path (priority) with a small FIFO of
// long-latency load/multiply results into the register file's only write
// port. It also keeps a per-register count of outstanding long-latency
// writes so decode can stall on RAW hazards.
module wb_arbiter #(
  parameter  int BITSIZE    = 64,
  parameter  int REGSIZE    = 32,
  parameter  int FIFO_DEPTH = 4,
  parameter  int ZERO_REG   = 31,
  localparam int SEL_W      = $clog2(REGSIZE)
) (
  input  logic               clk,
  input  logic               rst,
  // single-cycle ALU result
  input  logic               alu_valid,
  input  logic [SEL_W-1:0]   alu_dest,
  input  logic [BITSIZE-1:0] alu_data,
  // long-latency result offer
  input  logic               lsu_valid,
  output logic               lsu_ready,
  input  logic [SEL_W-1:0]   lsu_dest,
  input  logic [BITSIZE-1:0] lsu_data,
  // long-latency issue notification
  input  logic               issue_valid,
  input  logic [SEL_W-1:0]   issue_dest,
  // decode hazard query
  input  logic [SEL_W-1:0]   chk_sel1,
  input  logic [SEL_W-1:0]   chk_sel2,
  output logic               chk_busy1,
  output logic               chk_busy2,
  // register file write port
  output logic [SEL_W-1:0]   WriteSelect,
  output logic [BITSIZE-1:0] WriteData,
  output logic               WriteEnable,
  output logic               waw_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int SB_W  = $clog2(FIFO_DEPTH + 1) + 1;

  localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(ZERO_REG);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [SB_W-1:0]  SB_MAX   = '1;

  typedef struct packed {
    logic [SEL_W-1:0]   dest;
    logic [BITSIZE-1:0] data;
  } wb_entry_t;

  // FIFO state
  wb_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  // Scoreboard state
  logic [SB_W-1:0]  busy_cnt [REGSIZE];
  logic             waw_q;

  // Per-cycle control
  logic             alu_wr;
  logic             fifo_pop;
  logic             fifo_push;
  logic             alu_hazard;
  logic             sat_hit;
  wb_entry_t        head_entry;
  logic [REGSIZE-1:0] sb_inc;
  logic [REGSIZE-1:0] sb_dec;

  // XZR writes are dropped; the ALU owns the port whenever it has a real write.
  assign alu_wr     = alu_valid && (alu_dest != ZERO_SEL);
  assign head_entry = fifo_mem[head];
  assign fifo_pop   = !alu_wr && (count != '0);
  // Readiness ignores a same-cycle pop so it never depends on alu_valid.
  assign lsu_ready  = (count < DEPTH_C);
  // An XZR result is handshaken but never stored.
  assign fifo_push  = lsu_valid && lsu_ready && (lsu_dest != ZERO_SEL);

  // Register-file write port: ALU first, else drain the FIFO head.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned, which would infer a latch.
    WriteEnable = 1'b0;
    WriteSelect = '0;
    WriteData   = '0;
    if (alu_wr) begin
      WriteEnable = 1'b1;
      WriteSelect = alu_dest;
      WriteData   = alu_data;
    end else if (fifo_pop) begin
      WriteEnable = 1'b1;
      WriteSelect = head_entry.dest;
      WriteData   = head_entry.data;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (fifo_push) tail <= tail + PTR_W'(1);
      if (fifo_pop)  head <= head + PTR_W'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage, written at the tail on each accepted push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; empty is defined by count, and stale entries are never driven out.
    if (fifo_push) fifo_mem[tail] <= '{dest: lsu_dest, data: lsu_data};
  end

  // Per-register increment/decrement requests and saturation detection.
  always_comb begin
    sb_inc  = '0;
    sb_dec  = '0;
    sat_hit = 1'b0;
    for (int r = 0; r < REGSIZE; r++) begin
      if (r != ZERO_REG) begin
        sb_inc[r] = issue_valid && (issue_dest == SEL_W'(r));
        sb_dec[r] = fifo_pop && (head_entry.dest == SEL_W'(r));
      end
      if (sb_inc[r] && !sb_dec[r] && (busy_cnt[r] == SB_MAX)) sat_hit = 1'b1;
    end
  end

  // Pending-write counters: saturate at max, floor at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REGSIZE; r++) busy_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < REGSIZE; r++) begin
        case ({sb_inc[r], sb_dec[r]})
          2'b10:   if (busy_cnt[r] != SB_MAX) busy_cnt[r] <= busy_cnt[r] + SB_W'(1);
          2'b01:   if (busy_cnt[r] != '0)     busy_cnt[r] <= busy_cnt[r] - SB_W'(1);
          default: busy_cnt[r] <= busy_cnt[r];
        endcase
      end
    end
  end

  // An ALU write to a register with a pending long-latency result is a WAW.
  assign alu_hazard = alu_valid && (alu_dest != ZERO_SEL) && (busy_cnt[alu_dest] != '0);

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) waw_q <= 1'b0;
    else      waw_q <= waw_q | alu_hazard | sat_hit;
  end

  assign waw_err   = waw_q;
  assign chk_busy1 = (chk_sel1 != ZERO_SEL) && (busy_cnt[chk_sel1] != '0);
  assign chk_busy2 = (chk_sel2 != ZERO_SEL) && (busy_cnt[chk_sel2] != '0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based reference model predicts
// every register-file write and status output; a monitor pops predicted
// writes whenever the DUT asserts WriteEnable.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_dest;
  logic [63:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_dest;
  logic [63:0] lsu_data;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic [4:0]  chk_sel1;
  logic [4:0]  chk_sel2;
  logic        chk_busy1;
  logic        chk_busy2;
  logic [4:0]  WriteSelect;
  logic [63:0] WriteData;
  logic        WriteEnable;
  logic        waw_err;

  wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid   (alu_valid),
    .alu_dest    (alu_dest),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_dest    (lsu_dest),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_dest  (issue_dest),
    .chk_sel1    (chk_sel1),
    .chk_sel2    (chk_sel2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .WriteSelect (WriteSelect),
    .WriteData   (WriteData),
    .WriteEnable (WriteEnable),
    .waw_err     (waw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dest;
    logic [63:0] data;
  } wr_t;

  // Reference model state
  wr_t exp_q[$];    // predicted register-file writes, oldest first
  wr_t fifo_q[$];   // accepted long-latency results awaiting write
  int  cnt[32];     // outstanding long-latency writes per register
  bit  waw;         // expected sticky error
  int  sel1, sel2;  // decode query selects

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    fifo_q.delete();
    for (int r = 0; r < 32; r++) cnt[r] = 0;
    waw = 1'b0;
  endtask

  function automatic bit busy_of(input int sel);
    return (sel != 31) && (cnt[sel] != 0);
  endfunction

  // One clock cycle: drive inputs just after an edge, predict, check mid-cycle, advance model at the edge.
  task automatic step(input bit av, input int ad, input logic [63:0] adat,
                      input bit lv, input int ld, input logic [63:0] ldat,
                      input bit iv, input int id);
    bit  e_we, e_ready, pop, inc;
    int  hd;
    wr_t w;
    alu_valid   = av;  alu_dest   = 5'(ad); alu_data = adat;
    lsu_valid   = lv;  lsu_dest   = 5'(ld); lsu_data = ldat;
    issue_valid = iv;  issue_dest = 5'(id);
    chk_sel1    = 5'(sel1);
    chk_sel2    = 5'(sel2);
    e_ready = (fifo_q.size() < 4);
    e_we = 1'b0;
    pop  = 1'b0;
    hd   = 0;
    if (av && ad != 31) begin
      w.dest = ad; w.data = adat;
      exp_q.push_back(w);
      e_we = 1'b1;
    end else if (fifo_q.size() > 0) begin
      exp_q.push_back(fifo_q[0]);
      e_we = 1'b1;
      pop  = 1'b1;
      hd   = fifo_q[0].dest;
    end
    @(negedge clk);
    check("write_enable", WriteEnable, e_we);
    if (!e_we) begin
      check("idle_select", WriteSelect, 0);
      check("idle_data", WriteData, 0);
    end
    check("lsu_ready", lsu_ready, e_ready);
    check("chk_busy1", chk_busy1, busy_of(sel1));
    check("chk_busy2", chk_busy2, busy_of(sel2));
    check("waw_err", waw_err, waw);
    @(posedge clk);
    if (av && ad != 31 && cnt[ad] != 0) waw = 1'b1;
    if (pop) void'(fifo_q.pop_front());
    inc = iv && (id != 31);
    if (inc && !(pop && hd == id)) begin
      if (cnt[id] == 15) waw = 1'b1;
      else               cnt[id]++;
    end
    if (pop && !(inc && hd == id) && cnt[hd] > 0) cnt[hd]--;
    if (lv && e_ready && ld != 31) begin
      w.dest = ld; w.data = ldat;
      fifo_q.push_back(w);
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic mid_reset();
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    #2 rst = 1'b0;
    #1;
    check("rst_write_enable", WriteEnable, 0);
    check("rst_write_select", WriteSelect, 0);
    check("rst_write_data", WriteData, 0);
    check("rst_lsu_ready", lsu_ready, 1);
    check("rst_chk_busy1", chk_busy1, 0);
    check("rst_waw_err", waw_err, 0);
    check("rst_pending_writes", exp_q.size(), 0);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    check("rst_hold_write_enable", WriteEnable, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT write must match the oldest predicted write.
  always @(negedge clk) begin
    wr_t w;
    if (rst === 1'b1 && WriteEnable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: sel %0d data %h, none expected at %0t", WriteSelect, WriteData, $time);
      end else begin
        w = exp_q.pop_front();
        check("write_select", WriteSelect, w.dest);
        check("write_data", WriteData, w.data);
      end
    end
  end

  function automatic int rand_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 31 : r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    lsu_valid = 0; lsu_dest = 0; lsu_data = 0;
    issue_valid = 0; issue_dest = 0;
    chk_sel1 = 0; chk_sel2 = 0;
    sel1 = 0; sel2 = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset_write_enable", WriteEnable, 0);
    check("reset_lsu_ready", lsu_ready, 1);
    check("reset_waw_err", waw_err, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle after reset
    idle(2);

    // ALU write alone, then an ALU write to XZR that must be dropped
    step(1, 3, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 0, 0);
    step(1, 31, 64'h1111_2222_3333_4444, 0, 0, 0, 0, 0);

    // Issue dest 5, result arrives, written next cycle, busy clears after
    sel1 = 5; sel2 = 3;
    step(0, 0, 0, 0, 0, 0, 1, 5);
    step(0, 0, 0, 1, 5, 64'h1234, 0, 0);
    idle(2);

    // Fill the FIFO while the ALU holds the port, then drain
    sel1 = 1; sel2 = 4;
    for (int i = 1; i <= 4; i++) step(1, 7, 64'hA0 + i, 1, i, 64'h100 + i, 1, i);
    step(1, 7, 64'hA5, 1, 8, 64'h108, 0, 0);
    idle(5);

    // Two issues to x9; busy persists until the second write
    sel1 = 9; sel2 = 10;
    step(0, 0, 0, 0, 0, 0, 1, 9);
    step(0, 0, 0, 0, 0, 0, 1, 9);
    step(1, 2, 64'h22, 1, 9, 64'h9A, 0, 0);
    step(1, 2, 64'h23, 1, 9, 64'h9B, 0, 0);
    idle(3);
    // Same-cycle issue 9 and write 9
    step(0, 0, 0, 0, 0, 0, 1, 9);
    step(1, 2, 64'h24, 1, 9, 64'h9C, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 9);
    idle(2);

    // WAW: issue 6 then ALU writes 6; then reset with two queued results
    sel1 = 6; sel2 = 9;
    step(0, 0, 0, 0, 0, 0, 1, 6);
    step(1, 6, 64'h66, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 7, 64'h70, 1, 1, 64'h501, 0, 0);
    step(1, 7, 64'h71, 1, 2, 64'h502, 0, 0);
    mid_reset();
    idle(2);

    // Counter saturation
    sel1 = 12; sel2 = 31;
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 0, 1, 12);
    idle(2);
    mid_reset();

    // Randomised traffic, several phases separated by mid-operation resets
    for (int ph = 0; ph < 3; ph++) begin
      for (int c = 0; c < 300; c++) begin
        sel1 = rand_reg();
        sel2 = rand_reg();
        step(($urandom % 3) == 0, rand_reg(), {$urandom, $urandom},
             ($urandom % 2) == 0, rand_reg(), {$urandom, $urandom},
             ($urandom % 4) == 0, rand_reg());
      end
      mid_reset();
    end

    idle(2);
    check("final_pending_writes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
